enemy_control: RTL and testbench
================================

Name: enemy_control

Overview:
- Control FSM directly upstream of the single-enemy datapath.
- Sequences the enemy through its one-hot phases: init, idle, gen_move, apply_move and draw.
- Paces movement from the VGA frame tick and waits on the datapath's draw_done handshake.
- One instance per enemy; the top level ORs the VGA write strobes.

Parameters:
- MOVE_DIV, 2, frames per movement step (legal 1..15); every other frame is redraw-only.
- DRAW_TIMEOUT, 300, max cycles in DRAW before a forced exit (must be > 256, the sprite pixel count).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse; (re)initialises the enemy
- enable  in  1  1 = run; 0 = hold in IDLE after the current frame completes
- frame_tick  in  1  one-cycle pulse at vertical blank
- draw_done  in  1  from enemy datapath; high once all 256 pixels are issued
- init  out  1  phase strobe to datapath
- idle  out  1  phase strobe to datapath
- gen_move  out  1  phase strobe to datapath
- apply_move  out  1  phase strobe to datapath
- draw  out  1  phase strobe to datapath
- frame_done  out  1  one-cycle pulse when a frame's enemy work finishes
- tick_overrun  out  1  sticky; a frame_tick was lost
- draw_error  out  1  sticky; DRAW timed out

Behaviour:
- States:
  - S_OFF: all strobes 0.
  - S_INIT, S_IDLE, S_GEN, S_SETTLE, S_APPLY, S_DRAW, S_DONE.
- Phase outputs are registered and strictly one-hot or all-zero:
  - init=1 only in S_INIT.
  - idle=1 only in S_IDLE.
  - gen_move=1 only in S_GEN.
  - apply_move=1 only in S_APPLY.
  - draw=1 only in S_DRAW.
- Reset (reset=0, asynchronous):
  - state=S_OFF; all outputs 0.
  - frame counter=0, pending=0, timeout counter=0.
  - Reset takes effect mid-DRAW with no completion pulse.
- Transitions:
  - S_OFF: start -> S_INIT.
  - S_INIT lasts exactly 1 cycle -> S_IDLE.
  - start in any state other than S_OFF -> S_INIT next cycle. Also clears pending, the frame counter and both sticky flags.
  - S_IDLE: if (frame_tick or pending) and enable:
    - clear pending.
    - If frame counter == MOVE_DIV-1: counter <= 0, next S_GEN.
    - Else: counter++, next S_DRAW.
  - S_GEN, S_SETTLE, S_APPLY each last exactly 1 cycle, in that order, then -> S_DRAW. S_SETTLE gives the collision detector one cycle to evaluate the new direction before apply_move samples it.
  - S_DRAW:
    - draw_done=1 -> S_DONE.
    - draw_done is ignored in every other state; the datapath clears it whenever draw=0, so no stale done is possible.
    - Timeout counter starts at 0 on entry and increments every DRAW cycle. When it reaches DRAW_TIMEOUT-1 without draw_done: set draw_error, -> S_DONE.
  - S_DONE: frame_done=1 for 1 cycle -> S_IDLE.
- Tick buffering (one-deep):
  - frame_tick arriving outside S_IDLE, or while enable=0, sets pending.
  - A frame_tick arriving while pending is already 1 sets tick_overrun; pending stays 1.
  - frame_tick in S_IDLE with enable=1 is consumed directly and does not set pending.
- Latency: tick to draw rise is 1 cycle on a redraw frame and 4 cycles on a move frame.
- Counters are unsigned and wrap-free by construction: the frame counter is 4 bits, the timeout counter is 9 bits.

Optional Feature:
- Macro ENEMY_CTRL_STATS_EN.
- Defined: adds output move_count[15:0].
  - Increments once per S_APPLY cycle.
  - Wraps 0xFFFF -> 0.
  - Cleared by reset and by start.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset then start, enable=1, MOVE_DIV=2, ticks every 1000 cycles, draw_done returned 256 cycles after draw rises:
  - Frame 1: tick -> draw next cycle, no gen_move.
  - Frame 2: tick -> gen_move, (settle), apply_move, draw at cycles +1, +3, +4.
  - frame_done 1 cycle after draw_done.
- Hold draw_done=0 in DRAW -> draw stays high exactly 300 cycles; then draw_error=1 and frame_done pulses; next tick proceeds normally.
- frame_tick during DRAW -> pending set. After S_DONE the next frame starts immediately from S_IDLE with no new tick; tick_overrun=0.
- Two frame_ticks during one DRAW -> tick_overrun=1 (sticky until start or reset); only one extra frame runs.
- Assert reset=0 mid-DRAW, asynchronously between clock edges -> all strobes 0 immediately; after release, stays in S_OFF until start.
- enable=0 with ticks arriving -> stays in IDLE with pending=1. Raising enable -> frame begins next cycle. With ENEMY_CTRL_STATS_EN, move_count increments by 1 per move frame.

Source files
------------

// File: rtl/enemy_control.sv
// enemy_control: one-hot phase sequencer for a single enemy datapath, paced by the VGA frame tick.
// Optional feature: define ENEMY_CTRL_STATS_EN to add the move_count[15:0] output.
module enemy_control #(
   parameter int unsigned MOVE_DIV     = 2,
   parameter int unsigned DRAW_TIMEOUT = 300
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        enable,
   input  logic        frame_tick,
   input  logic        draw_done,
   output logic        init,
   output logic        idle,
   output logic        gen_move,
   output logic        apply_move,
   output logic        draw,
   output logic        frame_done,
   output logic        tick_overrun,
   output logic        draw_error
`ifdef ENEMY_CTRL_STATS_EN
   ,
   output logic [15:0] move_count
`endif
);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_GEN    = 3'd3,
      S_SETTLE = 3'd4,
      S_APPLY  = 3'd5,
      S_DRAW   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [3:0] LAST_FRAME = 4'(MOVE_DIV - 1);
   localparam logic [8:0] LAST_DRAW  = 9'(DRAW_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [3:0] frame_q, frame_d;
   logic [8:0] to_q, to_d;
   logic       pend_q, pend_d;
   logic       overrun_q, overrun_d;
   logic       derr_q, derr_d;
   logic       init_q, idle_q, gen_q, apply_q, draw_q, done_q;
   logic       go;

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      to_d      = 9'd0;
      pend_d    = pend_q;
      overrun_d = overrun_q;
      derr_d    = derr_q;
      go        = (state_q == S_IDLE) && enable && (frame_tick || pend_q);

      case (state_q)
         S_OFF: begin
            if (start) begin
               state_d = S_INIT;
            end else begin
               state_d = S_OFF;
            end
         end
         S_INIT:   state_d = S_IDLE;
         S_IDLE: begin
            if (go && (frame_q == LAST_FRAME)) begin
               frame_d = 4'd0;
               state_d = S_GEN;
            end else if (go) begin
               frame_d = frame_q + 4'd1;
               state_d = S_DRAW;
            end else begin
               state_d = S_IDLE;
            end
         end
         // SETTLE lets the collision detector see the new direction before APPLY samples it
         S_GEN:    state_d = S_SETTLE;
         S_SETTLE: state_d = S_APPLY;
         S_APPLY:  state_d = S_DRAW;
         S_DRAW: begin
            if (draw_done) begin
               state_d = S_DONE;
            end else if (to_q == LAST_DRAW) begin
               derr_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               to_d    = to_q + 9'd1;
               state_d = S_DRAW;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_OFF;
      endcase

      // one-deep tick buffer; a tick that finds the buffer full is reported, not queued
      if (go) begin
         pend_d = 1'b0;
      end else if (frame_tick) begin
         overrun_d = overrun_q | pend_q;
         pend_d    = 1'b1;
      end else begin
         pend_d = pend_q;
      end

      if (start) begin
         state_d   = S_INIT;
         frame_d   = 4'd0;
         to_d      = 9'd0;
         pend_d    = 1'b0;
         overrun_d = 1'b0;
         derr_d    = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // phase strobes are decoded from the next state so they register alongside it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_OFF;
         frame_q   <= 4'd0;
         to_q      <= 9'd0;
         pend_q    <= 1'b0;
         overrun_q <= 1'b0;
         derr_q    <= 1'b0;
         init_q    <= 1'b0;
         idle_q    <= 1'b0;
         gen_q     <= 1'b0;
         apply_q   <= 1'b0;
         draw_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         to_q      <= to_d;
         pend_q    <= pend_d;
         overrun_q <= overrun_d;
         derr_q    <= derr_d;
         init_q    <= (state_d == S_INIT);
         idle_q    <= (state_d == S_IDLE);
         gen_q     <= (state_d == S_GEN);
         apply_q   <= (state_d == S_APPLY);
         draw_q    <= (state_d == S_DRAW);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign init         = init_q;
   assign idle         = idle_q;
   assign gen_move     = gen_q;
   assign apply_move   = apply_q;
   assign draw         = draw_q;
   assign frame_done   = done_q;
   assign tick_overrun = overrun_q;
   assign draw_error   = derr_q;

`ifdef ENEMY_CTRL_STATS_EN
   logic [15:0] move_cnt_q;

   // counts APPLY cycles, wrapping naturally at 16 bits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         move_cnt_q <= 16'd0;
      end else if (start) begin
         move_cnt_q <= 16'd0;
      end else if (state_q == S_APPLY) begin
         move_cnt_q <= move_cnt_q + 16'd1;
      end else begin
         move_cnt_q <= move_cnt_q;
      end
   end

   assign move_count = move_cnt_q;
`endif

endmodule

// File: tb/tb_enemy_control.sv
// tb_enemy_control: randomized bench for enemy_control against a phase-script reference model.
// Set ENEMY_CTRL_STATS_EN to also check move_count.
module tb_enemy_control;

   localparam int MOVE_DIV     = 2;
   localparam int DRAW_TIMEOUT = 300;

   logic clock = 1'b0;
   logic reset, start, enable, frame_tick, draw_done;
   logic init, idle, gen_move, apply_move, draw, frame_done, tick_overrun, draw_error;
`ifdef ENEMY_CTRL_STATS_EN
   logic [15:0] move_count;
`endif

   enemy_control #(.MOVE_DIV(MOVE_DIV), .DRAW_TIMEOUT(DRAW_TIMEOUT)) dut (
      .clock(clock), .reset(reset), .start(start), .enable(enable),
      .frame_tick(frame_tick), .draw_done(draw_done),
      .init(init), .idle(idle), .gen_move(gen_move), .apply_move(apply_move),
      .draw(draw), .frame_done(frame_done), .tick_overrun(tick_overrun),
      .draw_error(draw_error)
`ifdef ENEMY_CTRL_STATS_EN
      , .move_count(move_count)
`endif
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the enemy runs a script of upcoming phases; an empty script means
   // it is waiting in IDLE (or OFF before the first start).
   typedef enum int {M_OFF, M_INIT, M_IDLE, M_GEN, M_SETTLE, M_APPLY, M_DRAW, M_DONE} ph_t;
   ph_t script[$];
   bit  m_on, m_pend, m_over, m_derr;
   int  m_frames, m_dcyc, m_lat, m_moves;
   int  force_lat = 0;
   bit  en_r = 1'b0;

   function automatic ph_t cur_phase();
      if (script.size() > 0) return script[0];
      return m_on ? M_IDLE : M_OFF;
   endfunction

   function automatic logic [7:0] model_vec();
      ph_t c = cur_phase();
      return {c == M_INIT, c == M_IDLE, c == M_GEN, c == M_APPLY, c == M_DRAW,
              c == M_DONE, m_over, m_derr};
   endfunction

   task automatic model_reset();
      script.delete();
      m_on = 0; m_pend = 0; m_over = 0; m_derr = 0;
      m_frames = 0; m_dcyc = 0; m_lat = 0; m_moves = 0;
   endtask

   task automatic model_step(input bit st, input bit en, input bit tk, input bit dd);
      ph_t c = cur_phase();
      bit  go;
      if (st) begin
         script.delete();
         script.push_back(M_INIT);
         m_on = 1; m_pend = 0; m_over = 0; m_derr = 0; m_frames = 0; m_moves = 0;
         return;
      end
      go = (c == M_IDLE) && en && (tk || m_pend);
      if (go) m_pend = 0;
      else if (tk) begin
         if (m_pend) m_over = 1;
         m_pend = 1;
      end
      if (c == M_APPLY) m_moves = (m_moves + 1) % 65536;
      if (c == M_DRAW) begin
         m_dcyc++;
         if (dd || m_dcyc == DRAW_TIMEOUT) begin
            if (!dd) m_derr = 1;
            script.delete();
            script.push_back(M_DONE);
         end
      end else if (script.size() > 0) begin
         void'(script.pop_front());
      end
      if (go) begin
         m_frames++;
         if (m_frames % MOVE_DIV == 0) begin
            script.push_back(M_GEN);
            script.push_back(M_SETTLE);
            script.push_back(M_APPLY);
         end
         script.push_back(M_DRAW);
         m_dcyc = 0;
         if (force_lat > 0) begin
            m_lat = force_lat;
            force_lat = 0;
         end else if ($urandom_range(0, 19) == 0) m_lat = 400;
         else if ($urandom_range(0, 9) == 0) m_lat = 256;
         else m_lat = $urandom_range(1, 40);
      end
   endtask

   logic [7:0] dut_vec;
   assign dut_vec = {init, idle, gen_move, apply_move, draw, frame_done, tick_overrun, draw_error};

   // one clock: inputs set at negedge, model advanced at posedge, outputs checked at next negedge
   task automatic cycle(input bit st, input bit tk);
      bit dd;
      dd = (cur_phase() == M_DRAW) && (m_dcyc >= m_lat);
      start = st; frame_tick = tk; enable = en_r; draw_done = dd;
      @(posedge clock);
      model_step(st, en_r, tk, dd);
      @(negedge clock);
      check("phase", 32'(dut_vec), 32'(model_vec()));
`ifdef ENEMY_CTRL_STATS_EN
      check("move_count", 32'(move_count), 32'(m_moves));
`endif
   endtask

   int nd;

   initial begin
      reset = 1'b0; start = 1'b0; enable = 1'b0; frame_tick = 1'b0; draw_done = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      check("reset", 32'(dut_vec), 32'(model_vec()));
      reset = 1'b1;
      repeat (3) cycle(0, 0);

      // start, then regular ticks with the datapath answering after 256 cycles
      en_r = 1'b1;
      cycle(1, 0);
      repeat (4) begin
         force_lat = 256;
         cycle(0, 1);
         repeat (999) cycle(0, 0);
      end

      // draw_done never arrives: draw must last exactly DRAW_TIMEOUT cycles
      force_lat = 1000;
      cycle(0, 1);
      nd = draw ? 1 : 0;
      repeat (400) begin
         cycle(0, 0);
         if (draw) nd++;
      end
      check("timeout_len", 32'(nd), 32'(DRAW_TIMEOUT));
      check("draw_error", 32'(draw_error), 32'd1);
      cycle(0, 1);
      repeat (300) cycle(0, 0);

      // one tick during DRAW is buffered, no overrun
      force_lat = 256;
      cycle(0, 1);
      repeat (10) cycle(0, 0);
      cycle(0, 1);
      repeat (800) cycle(0, 0);
      check("no_overrun", 32'(tick_overrun), 32'd0);

      // two ticks during one DRAW: overrun, only one extra frame
      force_lat = 256;
      cycle(0, 1);
      repeat (10) cycle(0, 0);
      cycle(0, 1);
      repeat (10) cycle(0, 0);
      cycle(0, 1);
      repeat (800) cycle(0, 0);
      check("overrun", 32'(tick_overrun), 32'd1);

      // asynchronous reset mid-DRAW
      force_lat = 256;
      cycle(0, 1);
      repeat (20) cycle(0, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("async_reset", 32'(dut_vec), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (5) cycle(0, 0);
      cycle(1, 0);

      // enable low: tick is held pending until enable rises
      en_r = 1'b0;
      repeat (5) cycle(0, 0);
      cycle(0, 1);
      repeat (50) cycle(0, 0);
      en_r = 1'b1;
      repeat (600) cycle(0, 0);

      // random traffic
      repeat (30000) begin
         if ($urandom_range(0, 299) == 0) en_r = ~en_r;
         cycle($urandom_range(0, 7999) == 0, $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
